imem_prog_ctrl: RTL and testbench

Load controller and arbiter for the writable instruction memory of the single-cycle RISC-V core. It shares the instruction store between the CPU fetch path and a byte-serial program loader. While a load is running it stalls the CPU, assembles incoming bytes into 32-bit little-endian words and writes them sequentially from word 0. On completion it pulses a CPU restart so execution resumes at PC 0 with the new program.

---
 rtl/imem_prog_ctrl.sv | 152 +++++++++++++++
 tb/tb_imem_prog_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_ctrl.sv
// Purpose: arbitrates the instruction store between CPU fetch and a byte-serial program loader.
// Latency: 4th byte accepted -> word write next cycle; last write -> cpu_restart pulse next cycle.
// Backpressure: byte_ready high only while collecting; the loader holds its byte otherwise.
module imem_prog_ctrl #(
    parameter int ADDR_BITS = 5,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          pc,
    output logic [ADDR_BITS-1:0] mem_raddr,
    output logic                 addr_fault,
    input  logic                 load_start,
    input  logic [ADDR_BITS-1:0] load_len,
    input  logic                 load_abort,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_waddr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_stall,
    output logic                 cpu_restart,
    output logic                 load_busy
);

    // One extra bit so a length of 2**ADDR_BITS words is representable.
    localparam int LEN_W = ADDR_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W-1:0]     r_len;
    logic [ADDR_BITS-1:0] r_word_cnt;
    logic [1:0]           r_byte_cnt;
    logic [23:0]          r_asm;
    logic [ADDR_BITS-1:0] r_waddr;
    logic [WIDTH-1:0]     r_wdata;

    logic w_byte_ready;
    logic w_stall;
    logic w_we;
    logic w_restart;
    logic w_accept;
    logic w_last_word;

    // A byte only counts when it is not being thrown away by an abort in the same cycle.
    assign w_accept    = (r_state == ST_COLLECT) && byte_valid && !load_abort;
    assign w_last_word = ({1'b0, r_word_cnt} == (r_len - LEN_W'(1)));

    // Fetch path is never blocked; the stalled CPU simply ignores reads during a load.
    assign mem_raddr  = pc[ADDR_BITS+1:2];
    assign addr_fault = ((pc >> (ADDR_BITS + 2)) != 16'd0) || (pc[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; abort in COLLECT/WRITE wins over everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_ready = 1'b0;
        w_stall      = 1'b0;
        w_we         = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_stall      = 1'b1;
                w_byte_ready = 1'b1;
                if (load_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (byte_valid && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_stall = 1'b1;
                if (load_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_we        = 1'b1;
                    w_state_nxt = w_last_word ? ST_DONE : ST_COLLECT;
                end
            end
            ST_DONE: begin
                w_restart   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Length/counters and little-endian word assembly; the write port registers hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && load_start) begin
                r_len      <= (load_len == '0) ? (LEN_W'(1) << ADDR_BITS) : {1'b0, load_len};
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
            end
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_asm[7:0]   <= byte_data;
                    2'd1: r_asm[15:8]  <= byte_data;
                    2'd2: r_asm[23:16] <= byte_data;
                    default: begin
                        r_wdata <= {byte_data, r_asm};
                        r_waddr <= r_word_cnt;
                    end
                endcase
            end
            if ((r_state == ST_WRITE) && !load_abort && !w_last_word) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign byte_ready  = w_byte_ready;
    assign cpu_stall   = w_stall;
    assign mem_we      = w_we;
    assign cpu_restart = w_restart;
    assign load_busy   = (r_state != ST_IDLE);
    assign mem_waddr   = r_waddr;
    assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Purpose: self-checking bench for imem_prog_ctrl using a word-level model of the load protocol.
// Latency: inputs driven on falling edges, outputs sampled away from the rising edge.
// Backpressure: the byte source holds each byte until it sees byte_ready.
module tb_imem_prog_ctrl;

    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   pc;
    logic [AB-1:0] mem_raddr;
    logic          addr_fault;
    logic          load_start;
    logic [AB-1:0] load_len;
    logic          load_abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AB-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_stall;
    logic          cpu_restart;
    logic          load_busy;

    imem_prog_ctrl #(.ADDR_BITS(AB), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .mem_raddr(mem_raddr), .addr_fault(addr_fault),
        .load_start(load_start), .load_len(load_len), .load_abort(load_abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .cpu_restart(cpu_restart), .load_busy(load_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] src[$];
    int         restart_cnt;
    int         restart_stall_bad;

    // Write/restart monitor, sampled mid-low-phase once the driver's inputs have settled.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (mem_we) wr_q.push_back('{int'(mem_waddr), mem_wdata});
            if (cpu_restart) begin
                restart_cnt++;
                if (cpu_stall) restart_stall_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fetch-side reference: word index modulo store size, fault outside store or misaligned.
    task automatic chk_pc(input logic [15:0] p);
        int exp_addr;
        int exp_fault;
        pc = p;
        #1;
        exp_addr  = (int'(p) / 4) % (1 << AB);
        exp_fault = (int'(p) >= 4 * (1 << AB) || (int'(p) % 4) != 0) ? 1 : 0;
        chk($sformatf("raddr pc=%0h", p), 32'(mem_raddr), 32'(exp_addr));
        chk($sformatf("fault pc=%0h", p), 32'(addr_fault), 32'(exp_fault));
    endtask

    // Expected writes: consecutive groups of 4 source bytes, first byte in the LSB, addresses from 0.
    task automatic chk_writes(input string tag, input int nwords);
        logic [31:0] w;
        chk({tag, " nwrites"}, 32'(wr_q.size()), 32'(nwords));
        for (int i = 0; i < nwords && i < wr_q.size(); i++) begin
            w = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
            chk($sformatf("%s addr%0d", tag, i), 32'(wr_q[i].addr), 32'(i));
            chk($sformatf("%s data%0d", tag, i), wr_q[i].data, w);
        end
    endtask

    // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
    task automatic run_load(input int len_field, input int mode, input int abort_at,
                            input int start_again, output int cycles, output int stall_cycles);
        int idx;
        idx = 0;
        wr_q.delete();
        restart_cnt = 0;
        restart_stall_bad = 0;
        @(negedge clk);
        load_len   = AB'(len_field);
        load_start = 1'b1;
        @(negedge clk);
        load_start   = 1'b0;
        cycles       = 1;
        stall_cycles = 0;
        while (load_busy && cycles < 2000) begin
            stall_cycles += int'(cpu_stall);
            load_start = (cycles == start_again);
            load_abort = (abort_at >= 0) && (idx == abort_at) && byte_ready;
            byte_valid = (idx < src.size()) &&
                         ((mode == 0) || (mode == 1 && cycles % 2 == 0) ||
                          (mode == 2 && $urandom_range(0, 2) != 0));
            byte_data  = (idx < src.size()) ? src[idx] : 8'h00;
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            cycles++;
        end
        load_start = 1'b0;
        load_abort = 1'b0;
        byte_valid = 1'b0;
        chk("load terminates", 32'(cycles < 2000), 32'd1);
    endtask

    initial begin
        int cyc;
        int stl;
        int nw;
        logic [7:0] prog2[8];

        rst_n = 1'b0; pc = 16'h0; load_start = 1'b0; load_len = '0;
        load_abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst byte_ready", 32'(byte_ready), 0);
        chk("rst cpu_stall", 32'(cpu_stall), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst busy", 32'(load_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch address decode: directed corners then random pcs.
        chk_pc(16'h0014);
        chk_pc(16'h0080);
        chk_pc(16'h0006);
        chk_pc(16'h007c);
        for (int i = 0; i < 8; i++) chk_pc(16'($urandom_range(0, 16'h00ff)));
        chk("idle cpu_stall", 32'(cpu_stall), 0);
        chk("idle byte_ready", 32'(byte_ready), 0);

        // Two-word program, streamed back-to-back.
        prog2 = '{8'h13, 8'h04, 8'h30, 8'h00, 8'h13, 8'h04, 8'h34, 8'h00};
        src.delete();
        foreach (prog2[i]) src.push_back(prog2[i]);
        run_load(2, 0, -1, -1, cyc, stl);
        chk_writes("b2b", 2);
        chk("b2b word0", wr_q.size() > 0 ? wr_q[0].data : 32'hx, 32'h00300413);
        chk("b2b cycles", 32'(cyc), 32'd12);
        chk("b2b stall cycles", 32'(stl), 32'd10);
        chk("b2b restarts", 32'(restart_cnt), 1);
        chk("b2b stall in restart", 32'(restart_stall_bad), 0);

        // Same program with valid toggling.
        run_load(2, 1, -1, -1, cyc, stl);
        chk_writes("toggle", 2);
        chk("toggle restarts", 32'(restart_cnt), 1);
        chk("toggle stall cycles", 32'(stl), 32'(cyc - 2));

        // Full store (length field 0), with a stray load_start mid-load.
        src.delete();
        for (int i = 0; i < 128; i++) src.push_back(8'($urandom));
        run_load(0, 0, -1, 50, cyc, stl);
        chk_writes("full", 32);
        chk("full cycles", 32'(cyc), 32'(5 * 32 + 2));
        chk("full restarts", 32'(restart_cnt), 1);

        // Abort after word 0 and two bytes of word 1.
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(8'($urandom));
        run_load(4, 0, 6, -1, cyc, stl);
        chk_writes("abort", 1);
        chk("abort restarts", 32'(restart_cnt), 0);
        chk("abort cpu_stall", 32'(cpu_stall), 0);
        chk("abort busy", 32'(load_busy), 0);
        chk("abort stall cycles", 32'(stl), 32'(cyc - 1));
        repeat (3) @(negedge clk);
        chk("abort no late write", 32'(wr_q.size()), 1);

        // Random lengths, data and gaps.
        for (int t = 0; t < 3; t++) begin
            nw = $urandom_range(1, 6);
            src.delete();
            for (int i = 0; i < 4 * nw; i++) src.push_back(8'($urandom));
            run_load(nw, 2, -1, -1, cyc, stl);
            chk_writes($sformatf("rand%0d", t), nw);
            chk($sformatf("rand%0d restarts", t), 32'(restart_cnt), 1);
            chk($sformatf("rand%0d min time", t), 32'(cyc >= 5 * nw + 2), 1);
        end

        // Asynchronous reset in the middle of collecting.
        @(negedge clk);
        load_len = AB'(1);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'haa;
        @(negedge clk);
        byte_data  = 8'hbb;
        @(negedge clk);
        byte_valid = 1'b0;
        chk("pre-reset stall", 32'(cpu_stall), 1);
        rst_n = 1'b0;
        #1;
        chk("arst cpu_stall", 32'(cpu_stall), 0);
        chk("arst byte_ready", 32'(byte_ready), 0);
        chk("arst mem_we", 32'(mem_we), 0);
        chk("arst waddr", 32'(mem_waddr), 0);
        chk("arst wdata", mem_wdata, 32'h0);
        chk("arst restart", 32'(cpu_restart), 0);
        chk("arst busy", 32'(load_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        src.delete();
        src.push_back(8'he3); src.push_back(8'h88); src.push_back(8'h0f); src.push_back(8'hfe);
        run_load(1, 0, -1, -1, cyc, stl);
        chk_writes("post-reset", 1);
        chk("post-reset word", wr_q.size() > 0 ? wr_q[0].data : 32'hx, 32'hfe0f88e3);
        chk("post-reset cycles", 32'(cyc), 32'd7);
        chk("post-reset restarts", 32'(restart_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
